// File: rtl/fp32_mul_sequencer.sv
// Multi-cycle FP32 multiplier: shift-add mantissa multiply, RNE rounding, DAZ/FTZ.
// Optional exception flags output enabled by defining FP_MUL_FLAGS_EN.
module fp32_mul_sequencer #(
   parameter int ITER_BITS = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_in_valid,
   output logic        io_in_ready,
   input  logic [31:0] io_a,
   input  logic [31:0] io_b,
   output logic        io_out_valid,
   input  logic        io_out_ready,
   output logic [31:0] io_result,
   output logic        io_busy
`ifdef FP_MUL_FLAGS_EN
   ,
   output logic [3:0]  io_flags
`endif
);
   localparam int N  = 24 / ITER_BITS;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_ROUND, S_DONE} state_t;

   state_t        r_state, w_next;
   logic          r_sign;
   logic [7:0]    r_ea, r_eb;
   logic [47:0]   r_mash;
   logic [23:0]   r_mb;
   logic [47:0]   r_acc;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_result;

   // Operand classification straight off the input bus, used only in the accept cycle
   logic w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_sign, w_invalid, w_special, w_accept;
   logic [31:0] w_sp_res;

   assign w_za      = (io_a[30:23] == 8'd0);
   assign w_zb      = (io_b[30:23] == 8'd0);
   assign w_ia      = (&io_a[30:23]) && (io_a[22:0] == 23'd0);
   assign w_ib      = (&io_b[30:23]) && (io_b[22:0] == 23'd0);
   assign w_na      = (&io_a[30:23]) && (|io_a[22:0]);
   assign w_nb      = (&io_b[30:23]) && (|io_b[22:0]);
   assign w_sign    = io_a[31] ^ io_b[31];
   assign w_invalid = w_na | w_nb | (w_ia & w_zb) | (w_ib & w_za);
   assign w_special = w_invalid | w_ia | w_ib | w_za | w_zb;
   assign w_sp_res  = w_invalid   ? 32'h7FC0_0000 :
                      (w_ia | w_ib) ? {w_sign, 8'hFF, 23'd0} : {w_sign, 31'd0};
   assign w_accept  = io_in_valid && (r_state == S_IDLE);

   // Partial product: multiplicand pre-shifted to the current digit position
   logic [47:0] w_mbits, w_pp;
   assign w_mbits = 48'(r_mb[ITER_BITS-1:0]);
   assign w_pp    = r_mash * w_mbits;

   logic signed [9:0] w_e0, w_e1, w_e2;
   logic [22:0] w_m;
   logic        w_g, w_s, w_ovf, w_unf;
   logic [23:0] w_rnd;
   logic [31:0] w_rnd_res;

   always_comb begin
      w_e0 = $signed({2'b00, r_ea}) + $signed({2'b00, r_eb}) - 10'sd127;
      if (r_acc[47]) begin
         w_m  = r_acc[46:24];
         w_g  = r_acc[23];
         w_s  = |r_acc[22:0];
         w_e1 = w_e0 + 10'sd1;
      end else begin
         w_m  = r_acc[45:23];
         w_g  = r_acc[22];
         w_s  = |r_acc[21:0];
         w_e1 = w_e0;
      end
      w_rnd     = {1'b0, w_m} + {23'd0, (w_g & (w_s | w_m[0]))};
      w_e2      = w_rnd[23] ? (w_e1 + 10'sd1) : w_e1;
      w_ovf     = (w_e2 >= 10'sd255);
      w_unf     = !w_ovf && (w_e2 <= 10'sd0);
      w_rnd_res = w_ovf ? {r_sign, 8'hFF, 23'd0} :
                  w_unf ? {r_sign, 31'd0} : {r_sign, w_e2[7:0], w_rnd[22:0]};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_special ? S_DONE : S_MULT;
         S_MULT:  if (r_cnt == CW'(N - 1)) w_next = S_ROUND;
         S_ROUND: w_next = S_DONE;
         S_DONE:  if (io_out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      io_in_ready  = (r_state == S_IDLE);
      io_busy      = (r_state != S_IDLE);
      io_out_valid = (r_state == S_DONE);
   end

   assign io_result = r_result;

`ifdef FP_MUL_FLAGS_EN
   logic [3:0] r_flags;
   assign io_flags = r_flags;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sign   <= 1'b0;
         r_ea     <= 8'd0;
         r_eb     <= 8'd0;
         r_mash   <= 48'd0;
         r_mb     <= 24'd0;
         r_acc    <= 48'd0;
         r_cnt    <= '0;
         r_result <= 32'd0;
`ifdef FP_MUL_FLAGS_EN
         r_flags  <= 4'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_sign <= w_sign;
               r_ea   <= io_a[30:23];
               r_eb   <= io_b[30:23];
               r_mash <= {24'd0, 1'b1, io_a[22:0]};
               r_mb   <= {1'b1, io_b[22:0]};
               r_acc  <= 48'd0;
               r_cnt  <= '0;
               if (w_special) r_result <= w_sp_res;
`ifdef FP_MUL_FLAGS_EN
               r_flags <= {w_invalid, 3'b000};
`endif
            end
            S_MULT: begin
               r_acc  <= r_acc + w_pp;
               r_mash <= r_mash << ITER_BITS;
               r_mb   <= r_mb >> ITER_BITS;
               r_cnt  <= r_cnt + CW'(1);
            end
            S_ROUND: begin
               r_result <= w_rnd_res;
`ifdef FP_MUL_FLAGS_EN
               r_flags  <= {1'b0, w_ovf, w_unf, (w_g | w_s | w_ovf | w_unf)};
`endif
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp32_mul_sequencer.sv
// Directed + randomized bench for fp32_mul_sequencer against an arithmetic reference model.
module tb_fp32_mul_sequencer;
   localparam int ITER = 1;
   localparam int N    = 24 / ITER;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        io_in_valid = 1'b0;
   logic        io_in_ready;
   logic [31:0] io_a = 32'd0;
   logic [31:0] io_b = 32'd0;
   logic        io_out_valid;
   logic        io_out_ready = 1'b0;
   logic [31:0] io_result;
   logic        io_busy;
`ifdef FP_MUL_FLAGS_EN
   logic [3:0]  io_flags;
`endif

   int nvec  = 0;
   int nfail = 0;

   always #5 clock = ~clock;

   fp32_mul_sequencer #(.ITER_BITS(ITER)) dut (
      .clock(clock), .reset(reset),
      .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
      .io_a(io_a), .io_b(io_b),
      .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
      .io_result(io_result), .io_busy(io_busy)
`ifdef FP_MUL_FLAGS_EN
      , .io_flags(io_flags)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns {special, flags[3:0], result[31:0]}
   function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b);
      int ea, eb, e, sh;
      logic s, za, zb, ia, ib, na, nb, inex;
      logic [63:0] p, mf, rem, half;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      s  = a[31] ^ b[31];
      za = (ea == 0);
      zb = (eb == 0);
      ia = (ea == 255) && (a[22:0] == 0);
      ib = (eb == 255) && (b[22:0] == 0);
      na = (ea == 255) && (a[22:0] != 0);
      nb = (eb == 255) && (b[22:0] != 0);
      if (na || nb || (ia && zb) || (ib && za)) return {1'b1, 4'b1000, 32'h7FC0_0000};
      if (ia || ib) return {1'b1, 4'b0000, s, 8'hFF, 23'd0};
      if (za || zb) return {1'b1, 4'b0000, s, 31'd0};
      p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
      e = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
      else sh = 23;
      mf   = p >> sh;
      rem  = p - (mf << sh);
      half = 64'd1 << (sh - 1);
      inex = (rem != 0);
      if (rem > half || (rem == half && mf[0])) mf = mf + 1;
      if (mf == (64'd1 << 24)) begin mf = mf >> 1; e = e + 1; end
      if (e >= 255) return {1'b0, 4'b0101, s, 8'hFF, 23'd0};
      if (e <= 0)   return {1'b0, 4'b0011, s, 31'd0};
      return {1'b0, 3'b000, inex, s, 8'(e), mf[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      int r;
      logic [7:0] e;
      logic [22:0] f;
      r = int'($urandom_range(0, 11));
      f = 23'($urandom);
      if (r == 0)      e = 8'd0;
      else if (r == 1) begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = 23'd0; end
      else if (r < 5)  e = 8'($urandom_range(1, 254));
      else             e = 8'($urandom_range(100, 154));
      return {1'($urandom), e, f};
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [36:0] exp;
      logic [31:0] held;
      int lat;
      exp = model(a, b);
      io_a = a; io_b = b; io_in_valid = 1'b1; io_out_ready = (hold == 0);
      chk("in_ready_idle", 64'(io_in_ready), 64'(1));
      @(posedge clock); #1;
      io_in_valid = 1'b0; io_a = $urandom; io_b = $urandom;
      lat = 1;
      while (!io_out_valid && lat < 100) begin
         chk("busy_wait", 64'(io_busy), 64'(1));
         @(posedge clock); #1;
         lat++;
      end
      chk("latency", 64'(lat), exp[36] ? 64'(1) : 64'(N + 2));
      chk("result", 64'(io_result), 64'(exp[31:0]));
      chk("busy_done", 64'(io_busy), 64'(1));
      chk("in_ready_done", 64'(io_in_ready), 64'(0));
`ifdef FP_MUL_FLAGS_EN
      chk("flags", 64'(io_flags), 64'(exp[35:32]));
`endif
      held = io_result;
      for (int i = 0; i < hold; i++) begin
         io_in_valid = 1'b1; io_a = $urandom; io_b = $urandom;
         @(posedge clock); #1;
         chk("bp_valid", 64'(io_out_valid), 64'(1));
         chk("bp_hold", 64'(io_result), 64'(held));
         chk("bp_in_ready", 64'(io_in_ready), 64'(0));
      end
      io_out_ready = 1'b1;
      @(posedge clock); #1;
      io_in_valid = 1'b0; io_out_ready = 1'b0;
      chk("valid_drop", 64'(io_out_valid), 64'(0));
      chk("ready_after", 64'(io_in_ready), 64'(1));
      chk("result_keep", 64'(io_result), 64'(held));
   endtask

   initial begin
      int stale;
      #12;
      chk("rst_result", 64'(io_result), 64'(0));
      chk("rst_valid", 64'(io_out_valid), 64'(0));
      chk("rst_busy", 64'(io_busy), 64'(0));
      chk("rst_in_ready", 64'(io_in_ready), 64'(1));
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;

      run_op(32'h3FC0_0000, 32'h4000_0000, 0);   // 1.5 * 2.0
      run_op(32'h3F80_0001, 32'h3F80_0001, 0);   // sticky only, no round-up
      run_op(32'h7F80_0000, 32'h0000_0000, 0);   // inf * 0
      run_op(32'hFF80_0000, 32'h4000_0000, 0);   // -inf * 2
      run_op(32'h7F7F_FFFF, 32'h4000_0000, 0);   // overflow
      run_op(32'h0080_0000, 32'h3F00_0000, 0);   // underflow flush
      run_op(32'h3FC0_0000, 32'h4000_0000, 5);   // backpressure
      run_op(32'h4049_0FDB, 32'hC02D_F854, 1);   // back-to-back accept after handshake

      // Abort mid-multiply with asynchronous reset
      io_a = 32'h3FC0_0000; io_b = 32'h4000_0000; io_in_valid = 1'b1;
      @(posedge clock); #1;
      io_in_valid = 1'b0;
      repeat (9) @(posedge clock);
      #1;
      chk("mid_busy", 64'(io_busy), 64'(1));
      #2 reset = 1'b0;
      #1;
      chk("abort_valid", 64'(io_out_valid), 64'(0));
      chk("abort_result", 64'(io_result), 64'(0));
      chk("abort_busy", 64'(io_busy), 64'(0));
      chk("abort_in_ready", 64'(io_in_ready), 64'(1));
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      stale = 0;
      repeat (30) begin
         @(posedge clock); #1;
         if (io_out_valid) stale++;
      end
      chk("no_stale", 64'(stale), 64'(0));
      run_op(32'h3FC0_0000, 32'h4000_0000, 0);

      for (int k = 0; k < 40; k++)
         run_op(rand_fp(), rand_fp(), int'($urandom_range(0, 3)));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule

// File: doc/fp32_mul_sequencer.md
Name: fp32_mul_sequencer

Overview:
- Multi-cycle IEEE-754 single-precision multiplier controller with valid/ready handshakes on both input and output.
- Unpacks the operands into sign, exponent and mantissa fields (sign = bit 31, exponent = bits 30:23, mantissa = bits 22:0).
- Sequences an iterative shift-add mantissa multiply, then normalises, rounds and repacks the result.
- Sits between the FP32 field-split logic and downstream consumers. One shared multiplier array serves one operation at a time.

Parameters:
- ITER_BITS, 1, multiplier bits consumed per MULT cycle. Legal values: 1, 2, 3, 4, 6, 8 (must divide 24). Number of MULT cycles N = 24/ITER_BITS.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- io_in_valid  input  1  operand pair valid.
- io_in_ready  output  1  block can accept an operand pair.
- io_a  input  32  FP32 operand A.
- io_b  input  32  FP32 operand B.
- io_out_valid  output  1  io_result valid.
- io_out_ready  input  1  consumer accepts io_result.
- io_result  output  32  FP32 product.
- io_busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, MULT, ROUND, DONE. All outputs are registered or decoded from state.
- Reset (reset=0, asynchronous):
  - state=IDLE, io_result=0, io_out_valid=0, io_busy=0, io_in_ready=1.
  - Reset asserted mid-operation aborts the operation; no result is emitted.
- io_in_ready=1 only in IDLE. Accept occurs when io_in_valid && io_in_ready.
- On accept:
  - Register sa, sb, ea, eb, and ma={1,frac}/mb={1,frac}.
  - sign = sa^sb.
  - Classify operands: exponent 0 is treated as zero (denormals-are-zero, fraction ignored); exponent 255 with fraction 0 is inf; exponent 255 with fraction nonzero is NaN.
- Special-case results; for each, load io_result and go IDLE -> DONE (out_valid one cycle after accept):
  - Either operand NaN, or inf x zero: result 0x7FC00000 (canonical NaN, sign 0).
  - inf x nonzero finite, or inf x inf: result {sign, 0xFF, 0}.
  - zero x finite/zero: result {sign, 31'b0}.
- Normal path, IDLE -> MULT:
  - 48-bit accumulator and a cycle counter starting at 0.
  - Each MULT cycle adds ma x (next ITER_BITS of mb, LSB first), shifted to the correct position.
  - Counter reaches N-1 -> ROUND.
- ROUND (one cycle), with product p[47:0] and exponent e = ea + eb - 127 (10-bit signed):
  - p[47]=1: m=p[46:24], g=p[23], s=|p[22:0], e=e+1.
  - Otherwise: m=p[45:23], g=p[22], s=|p[21:0].
  - Round to nearest even: increment m if g && (s || m[0]). If the increment carries out of 23 bits, m=0 and e=e+1.
  - e >= 255: result {sign, 0xFF, 0} (overflow to inf).
  - e <= 0: result {sign, 31'b0} (flush to zero, no subnormal outputs).
  - Otherwise: result {sign, e[7:0], m}.
  - Next state DONE.
- Latency from accept to io_out_valid: normal path N+2 cycles (26 at default); special path 1 cycle.
- DONE:
  - io_out_valid=1; io_result is held stable while io_out_ready=0.
  - io_out_valid && io_out_ready -> IDLE. io_out_valid drops the next cycle; io_result holds its last value.
  - An input cannot be accepted in the same cycle as the output handshake; the earliest next accept is the cycle after.
- Input changes on io_a/io_b outside the accept cycle have no effect.

Optional Feature:
- Macro FP_MUL_FLAGS_EN.
- Defined: adds output io_flags [3:0] = {invalid, overflow, underflow, inexact}.
  - Flags are registered together with io_result and valid while io_out_valid=1.
  - Reset value 0; cleared on each accept.
  - invalid: NaN input or inf x 0.
  - overflow: e >= 255 after rounding.
  - underflow: flushed to zero from a nonzero product.
  - inexact: g||s on the normal path, or overflow/underflow set.
- Not defined: io_flags port and all flag logic are absent; all other behaviour is identical.

Test Plan:
1. 0x3FC00000 x 0x40000000, out_ready=1 -> io_result=0x40400000, out_valid exactly 26 cycles after accept, busy high throughout, flags=0.
2. 0x3F800001 x 0x3F800001 -> 0x3F800002 (g=0, s=1, no round-up); flags inexact=1.
3. inf x zero: 0x7F800000 x 0x00000000 -> 0x7FC00000 one cycle after accept, invalid=1. Also 0xFF800000 x 0x40000000 -> 0xFF800000.
4. 0x7F7FFFFF x 0x40000000 -> 0x7F800000, overflow=1, inexact=1. Also 0x00800000 x 0x3F000000 -> 0x00000000, underflow=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, in_valid ignored. Release -> IDLE next cycle, new accept the cycle after.
6. Assert reset mid-MULT (cycle 10) -> outputs at reset values immediately. After release, a fresh 1.5 x 2.0 yields 0x40400000 with no stale result emitted.
